// File: rtl/param_stack.sv
// param_stack: parametrised LIFO stack with a registered read port.
//
// Parameters:
//   DATA_W  - width of each entry
//   DEPTH   - number of entries (>= 2, any value)
//   CNT_W   - width of count, $clog2(DEPTH+1)
//
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-high reset
//   clear             - synchronous flush (count and error flags), beats push/pop/tos
//   push, pop, tos    - command strobes; push+pop replaces the top entry
//   data_in           - push data
//   data_out          - registered read data, holds between reads
//   out_valid         - single-cycle strobe, data_out was updated by this edge
//   count             - number of stored entries
//   empty, full       - decoded from the registered count only
//   overflow          - sticky, set by a push rejected while full
//   underflow         - sticky, set by pop/tos attempted while empty
module param_stack #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic              tos,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic             wr_en;
  logic             rd_en;
  logic             set_ovf;
  logic             set_udf;
  logic [CNT_W-1:0] cnt_nxt;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign top_idx = AW'(count - CNT_W'(1));

  // Command decode, evaluated against the count before the edge.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    rd_en   = 1'b0;
    set_ovf = 1'b0;
    set_udf = 1'b0;
    cnt_nxt = count;
    if (!clear) begin
      if (push && pop) begin
        // Replace top; on an empty stack this degrades to a plain push.
        wr_en = 1'b1;
        if (empty) begin
          wr_idx  = '0;
          cnt_nxt = CNT_W'(1);
        end else begin
          rd_en  = 1'b1;
          wr_idx = top_idx;
        end
      end else if (push) begin
        // push+tos reads the pre-push top, then normal push rules apply.
        if (tos) begin
          if (empty) set_udf = 1'b1;
          else       rd_en   = 1'b1;
        end
        if (full) begin
          set_ovf = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_idx  = AW'(count);
          cnt_nxt = count + CNT_W'(1);
        end
      end else if (pop || tos) begin
        if (empty) begin
          set_udf = 1'b1;
        end else begin
          rd_en = 1'b1;
          if (pop) cnt_nxt = count - CNT_W'(1);
        end
      end
    end
  end

  // Storage is not reset; contents above count are don't-care.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_idx] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      count     <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= cnt_nxt;
      out_valid <= rd_en;
      if (rd_en)   data_out  <= mem[top_idx];
      if (set_ovf) overflow  <= 1'b1;
      if (set_udf) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_param_stack.sv
module tb_param_stack;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: DATA_W=8, DEPTH=4
  logic       clear_a = 1'b0, push_a = 1'b0, pop_a = 1'b0, tos_a = 1'b0;
  logic [7:0] din_a = '0;
  logic [7:0] dout_a;
  logic       valid_a, empty_a, full_a, ovf_a, udf_a;
  logic [2:0] count_a;

  // Instance B: DATA_W=16, DEPTH=5
  logic        clear_b = 1'b0, push_b = 1'b0, pop_b = 1'b0, tos_b = 1'b0;
  logic [15:0] din_b = '0;
  logic [15:0] dout_b;
  logic        valid_b, empty_b, full_b, ovf_b, udf_b;
  logic [2:0]  count_b;

  param_stack #(.DATA_W(8), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .clear(clear_a), .push(push_a), .pop(pop_a), .tos(tos_a),
    .data_in(din_a), .data_out(dout_a), .out_valid(valid_a), .count(count_a),
    .empty(empty_a), .full(full_a), .overflow(ovf_a), .underflow(udf_a)
  );

  param_stack #(.DATA_W(16), .DEPTH(5)) dut_b (
    .clk(clk), .rst(rst), .clear(clear_b), .push(push_b), .pop(pop_b), .tos(tos_b),
    .data_in(din_b), .data_out(dout_b), .out_valid(valid_b), .count(count_b),
    .empty(empty_b), .full(full_b), .overflow(ovf_b), .underflow(udf_b)
  );

  typedef struct {
    logic        clr, ps, pp, ts;
    logic [15:0] din;
    logic [15:0] eout;
    logic        ev;
    int          ecnt;
    logic        eovf, eudf;
  } vec_t;

  vec_t va[$];
  vec_t vb[$];

  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(logic c, logic p, logic q, logic t, logic [15:0] d,
                              logic [15:0] e, logic v, int n, logic o, logic u);
    vec_t r;
    r.clr = c; r.ps = p; r.pp = q; r.ts = t; r.din = d;
    r.eout = e; r.ev = v; r.ecnt = n; r.eovf = o; r.eudf = u;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(bit sel_b, string tag, logic [15:0] eout, logic ev,
                             int ecnt, logic eovf, logic eudf);
    logic [15:0] d;
    logic v, e, f, o, u;
    logic [2:0] c;
    int depth;
    if (sel_b) begin
      d = dout_b; v = valid_b; c = count_b; e = empty_b; f = full_b; o = ovf_b; u = udf_b;
      depth = 5;
    end else begin
      d = {8'h00, dout_a}; v = valid_a; c = count_a; e = empty_a; f = full_a; o = ovf_a; u = udf_a;
      depth = 4;
    end
    check({tag, ".data_out"},  32'(d), 32'(eout));
    check({tag, ".out_valid"}, 32'(v), 32'(ev));
    check({tag, ".count"},     32'(c), 32'(ecnt));
    check({tag, ".empty"},     32'(e), 32'(ecnt == 0));
    check({tag, ".full"},      32'(f), 32'(ecnt == depth));
    check({tag, ".overflow"},  32'(o), 32'(eovf));
    check({tag, ".underflow"}, 32'(u), 32'(eudf));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic apply_a(vec_t v, string tag);
    clear_a = v.clr; push_a = v.ps; pop_a = v.pp; tos_a = v.ts; din_a = v.din[7:0];
    @(posedge clk); #1;
    clear_a = 1'b0; push_a = 1'b0; pop_a = 1'b0; tos_a = 1'b0;
    check_state(1'b0, tag, v.eout, v.ev, v.ecnt, v.eovf, v.eudf);
  endtask

  task automatic apply_b(vec_t v, string tag);
    clear_b = v.clr; push_b = v.ps; pop_b = v.pp; tos_b = v.ts; din_b = v.din;
    @(posedge clk); #1;
    clear_b = 1'b0; push_b = 1'b0; pop_b = 1'b0; tos_b = 1'b0;
    check_state(1'b1, tag, v.eout, v.ev, v.ecnt, v.eovf, v.eudf);
  endtask

  initial begin
    // Instance A table: clr ps pp ts din | data_out valid count ovf udf
    va.push_back(mk(0,1,0,0,16'h11, 16'h00,0,1,0,0));
    va.push_back(mk(0,1,0,0,16'h22, 16'h00,0,2,0,0));
    va.push_back(mk(0,1,0,0,16'h33, 16'h00,0,3,0,0));
    va.push_back(mk(0,1,0,0,16'h44, 16'h00,0,4,0,0));
    va.push_back(mk(0,1,0,0,16'h55, 16'h00,0,4,1,0));   // overflow
    va.push_back(mk(0,0,1,0,16'h00, 16'h44,1,3,1,0));
    va.push_back(mk(0,0,1,0,16'h00, 16'h33,1,2,1,0));
    va.push_back(mk(0,0,1,0,16'h00, 16'h22,1,1,1,0));
    va.push_back(mk(0,0,1,0,16'h00, 16'h11,1,0,1,0));
    va.push_back(mk(0,0,1,0,16'h00, 16'h11,0,0,1,1));   // pop on empty
    va.push_back(mk(0,0,0,1,16'h00, 16'h11,0,0,1,1));   // tos on empty
    va.push_back(mk(1,0,0,0,16'h00, 16'h11,0,0,0,0));   // clear
    va.push_back(mk(0,1,0,0,16'hA5, 16'h11,0,1,0,0));
    va.push_back(mk(0,0,0,1,16'h00, 16'hA5,1,1,0,0));
    va.push_back(mk(0,0,1,0,16'h00, 16'hA5,1,0,0,0));
    va.push_back(mk(0,1,0,0,16'h11, 16'hA5,0,1,0,0));
    va.push_back(mk(0,1,0,0,16'h22, 16'hA5,0,2,0,0));
    va.push_back(mk(0,1,0,0,16'h33, 16'hA5,0,3,0,0));
    va.push_back(mk(0,1,0,0,16'h44, 16'hA5,0,4,0,0));
    va.push_back(mk(0,1,1,0,16'h99, 16'h44,1,4,0,0));   // replace top while full
    va.push_back(mk(0,0,1,0,16'h00, 16'h99,1,3,0,0));
    va.push_back(mk(0,0,1,0,16'h00, 16'h33,1,2,0,0));
    va.push_back(mk(0,0,1,0,16'h00, 16'h22,1,1,0,0));
    va.push_back(mk(0,0,1,0,16'h00, 16'h11,1,0,0,0));
    va.push_back(mk(0,1,1,0,16'h7E, 16'h11,0,1,0,0));   // push+pop on empty
    va.push_back(mk(0,1,0,1,16'h3C, 16'h7E,1,2,0,0));   // push+tos
    va.push_back(mk(0,1,0,0,16'h01, 16'h7E,0,3,0,0));
    va.push_back(mk(0,1,0,0,16'h02, 16'h7E,0,4,0,0));
    va.push_back(mk(0,1,0,1,16'h03, 16'h02,1,4,1,0));   // push+tos while full
    va.push_back(mk(0,0,1,1,16'h00, 16'h02,1,3,1,0));   // pop+tos
    va.push_back(mk(0,0,1,0,16'h00, 16'h01,1,2,1,0));
    va.push_back(mk(1,0,0,0,16'h00, 16'h01,0,0,0,0));
    va.push_back(mk(0,1,0,1,16'h5A, 16'h01,0,1,0,1));   // push+tos on empty
    va.push_back(mk(0,0,1,0,16'h00, 16'h5A,1,0,0,1));
    va.push_back(mk(1,0,0,0,16'h00, 16'h5A,0,0,0,0));
    va.push_back(mk(0,1,0,0,16'h01, 16'h5A,0,1,0,0));
    va.push_back(mk(0,1,0,0,16'h02, 16'h5A,0,2,0,0));
    va.push_back(mk(0,1,0,0,16'h03, 16'h5A,0,3,0,0));
    va.push_back(mk(1,1,0,0,16'h77, 16'h5A,0,0,0,0));   // clear beats push
    va.push_back(mk(0,1,0,0,16'h88, 16'h5A,0,1,0,0));
    va.push_back(mk(0,1,1,1,16'h66, 16'h88,1,1,0,0));   // push+pop+tos
    va.push_back(mk(0,0,1,0,16'h00, 16'h66,1,0,0,0));

    // Instance B table: fill to 5, overflow, drain
    vb.push_back(mk(0,1,0,0,16'h1111, 16'h0000,0,1,0,0));
    vb.push_back(mk(0,1,0,0,16'h2222, 16'h0000,0,2,0,0));
    vb.push_back(mk(0,1,0,0,16'h3333, 16'h0000,0,3,0,0));
    vb.push_back(mk(0,1,0,0,16'h4444, 16'h0000,0,4,0,0));
    vb.push_back(mk(0,1,0,0,16'h5555, 16'h0000,0,5,0,0));
    vb.push_back(mk(0,1,0,0,16'h6666, 16'h0000,0,5,1,0));
    vb.push_back(mk(0,0,1,0,16'h0000, 16'h5555,1,4,1,0));
    vb.push_back(mk(0,0,1,0,16'h0000, 16'h4444,1,3,1,0));
    vb.push_back(mk(0,0,1,0,16'h0000, 16'h3333,1,2,1,0));
    vb.push_back(mk(0,0,1,0,16'h0000, 16'h2222,1,1,1,0));
    vb.push_back(mk(0,0,1,0,16'h0000, 16'h1111,1,0,1,0));
    vb.push_back(mk(0,0,1,0,16'h0000, 16'h1111,0,0,1,1));

    // Reset state, checked while rst is still asserted
    #1;
    check_state(1'b0, "reset_a", 16'h0, 1'b0, 0, 1'b0, 1'b0);
    check_state(1'b1, "reset_b", 16'h0, 1'b0, 0, 1'b0, 1'b0);
    #11 rst = 1'b0;

    // Two pushes and a tos, then an asynchronous reset mid-sequence
    apply_a(mk(0,1,0,0,16'h11, 16'h00,0,1,0,0), "pre0");
    apply_a(mk(0,1,0,0,16'h22, 16'h00,0,2,0,0), "pre1");
    apply_a(mk(0,0,0,1,16'h00, 16'h22,1,2,0,0), "pre2");
    #2 rst = 1'b1;
    #1 check_state(1'b0, "async_rst", 16'h0, 1'b0, 0, 1'b0, 1'b0);
    #2 rst = 1'b0;

    for (int unsigned i = 0; i < va.size(); i++)
      apply_a(va[i], $sformatf("a%0d", i));
    for (int unsigned i = 0; i < vb.size(); i++)
      apply_b(vb[i], $sformatf("b%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_stack.md
Name: param_stack

Overview:
Parametrised LIFO stack; next generation of the team's 8-bit stack, generalised in data width and depth. Adds full/empty/count status, sticky overflow/underflow error flags, a synchronous clear, a defined push+pop "replace top" operation, and a registered read port with a valid strobe. Used as an operand/return-address stack in the datapath, driven by controller one-hot command strobes.

Parameters:
DATA_W, 8, width of each stack entry in bits
DEPTH, 8, number of entries (>=2; need not be a power of two)
CNT_W (localparam), $clog2(DEPTH+1), width of count output

Ports:
clk  input  1  clock, rising-edge active
rst  input  1  asynchronous reset, active-high
clear  input  1  synchronous flush: empties stack, clears error flags
push  input  1  push data_in onto stack
pop  input  1  pop top entry to data_out
tos  input  1  read top entry to data_out without removing it
data_in  input  DATA_W  write data for push
data_out  output  DATA_W  registered read data
out_valid  output  1  one-cycle strobe: data_out updated this cycle
count  output  CNT_W  current number of stored entries
empty  output  1  count == 0 (combinational from count)
full  output  1  count == DEPTH (combinational from count)
overflow  output  1  sticky: push rejected while full
underflow  output  1  sticky: pop/tos attempted while empty

Behaviour:
- Reset (async, rst=1): count=0, data_out=0, out_valid=0, overflow=0, underflow=0; empty=1, full=0. Memory contents not reset (don't-care). Ops ignored while rst high.
- Storage: mem[0..DEPTH-1]; top entry at mem[count-1]. No pointer wrap; count saturates in [0, DEPTH].
- All state changes on rising clk; data_out/out_valid valid the cycle after the command edge (1-cycle latency). out_valid is a single-cycle pulse, 0 whenever no read occurs; data_out holds last value otherwise.
- Priority: rst > clear > (push/pop/tos decode). clear: count<=0, overflow<=0, underflow<=0, out_valid<=0; push/pop/tos in same cycle ignored.
- Decode (clear=0), evaluated against count before the edge:
  - push only, not full: mem[count]<=data_in, count+1.
  - push only, full: no write, count unchanged, overflow<=1.
  - pop only, not empty: data_out<=mem[count-1], out_valid<=1, count-1.
  - pop only, empty: count unchanged, out_valid<=0, underflow<=1.
  - tos only, not empty: data_out<=mem[count-1], out_valid<=1, count unchanged.
  - tos only, empty: out_valid<=0, underflow<=1.
  - pop+tos: identical to pop only (tos redundant).
  - push+pop (tos ignored), not empty: replace top: data_out<=old mem[count-1], out_valid<=1, mem[count-1]<=data_in, count unchanged; legal when full, no overflow.
  - push+pop, empty: treated as push only (count becomes 1), no underflow, out_valid<=0.
  - push+tos (no pop), not empty: data_out<=old top (pre-push), out_valid<=1, then push rules apply (incl. overflow if full).
  - push+tos, empty: push performed, out_valid<=0, underflow<=1.
- Error flags sticky until clear or rst; never block further legal operations.
- No combinational path from inputs to data_out/out_valid; empty/full derived only from registered count.

Test Plan:
- DATA_W=8, DEPTH=4: rst mid-sequence after 2 pushes -> count=0, empty=1, data_out=0, out_valid=0 immediately (async), flags 0.
- Push 0x11,0x22,0x33,0x44 -> full=1, count=4; 5th push 0x55 -> overflow=1, count=4; pop x4 -> data_out 0x44,0x33,0x22,0x11 each with out_valid pulse, empty=1.
- Empty stack: pop -> underflow=1, out_valid=0, count=0; tos -> same; then clear -> underflow=0; push 0xA5, tos -> data_out=0xA5, count=1.
- Full stack (top 0x44): push+pop with data_in 0x99 -> data_out=0x44, out_valid=1, count=4, no overflow; next pop -> 0x99.
- Empty: push+pop data_in 0x7E -> count=1, out_valid=0, no underflow; push+tos data_in 0x3C -> data_out=0x7E, count=2.
- clear asserted with push same cycle after 3 entries -> count=0, no write; DEPTH=5, DATA_W=16 rerun of fill/drain -> full at count=5, CNT_W=3.
